// File: rtl/ibex_fp_div_bf16.sv
// ibex_fp_div_bf16 - iterative bfloat16 divider behind the execute block.
//
// Handshake: the execute block holds div_en_i high for the whole operation
// and operands are captured in the IDLE cycle where div_en_i is first seen
// high. valid_o is high exactly while the FSM sits in DONE. result_o and
// flags_o stay stable in DONE until div_en_i & ready_id_i completes the
// handshake. div_en_i low in any non-IDLE state aborts back to IDLE and
// discards the result.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   div_en_i           dynamic enable (low aborts)
//   operand_a_i/b_i    dividend / divisor, bf16 in [31:16]
//   ready_id_i         ID stage accepts the result
//   valid_o            result and flags valid (state == DONE)
//   busy_o             state is not IDLE
//   result_o           bf16 quotient in [31:16], [15:0] zero
//   flags_o            {NV, DZ, OF, UF, NX}
//   dbg_state_o        current FSM state (0 IDLE, 1 DIV, 2 NORM, 3 DONE)
module ibex_fp_div_bf16 #(
    parameter int unsigned NumIter = 11
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        div_en_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        ready_id_i,
    output logic        valid_o,
    output logic        busy_o,
    output logic [31:0] result_o,
    output logic [4:0]  flags_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_NORM = 2'd2, S_DONE = 2'd3} state_t;

    localparam logic [3:0] LastCnt = 4'(NumIter - 1);

    state_t             r_state, w_next;
    logic [3:0]         r_cnt;
    logic [8:0]         r_rem;
    logic [7:0]         r_mb;
    logic [10:0]        r_q;
    logic signed [9:0]  r_exp;   // e_a - e_b + 126
    logic               r_sign;
    logic [15:0]        r_res;
    logic [4:0]         r_flags;

    // Operand decode
    logic [7:0] w_ea, w_eb;
    logic [6:0] w_fa, w_fb;
    logic       w_sign;
    logic       w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic       w_unused;

    assign w_ea     = operand_a_i[30:23];
    assign w_fa     = operand_a_i[22:16];
    assign w_eb     = operand_b_i[30:23];
    assign w_fb     = operand_b_i[22:16];
    assign w_sign   = operand_a_i[31] ^ operand_b_i[31];
    assign w_a_zero = (w_ea == 8'd0);
    assign w_b_zero = (w_eb == 8'd0);
    assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 7'd0);
    assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 7'd0);
    assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 7'd0);
    assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 7'd0);
    assign w_unused = ^{operand_a_i[15:0], operand_b_i[15:0]};

    // Special-case resolution (priority order matters: NaN cases first)
    logic        w_special;
    logic [15:0] w_spec_res;
    logic [4:0]  w_spec_flags;

    always_comb begin
        w_special    = 1'b1;
        w_spec_res   = 16'h0000;
        w_spec_flags = 5'b00000;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_res   = 16'h7FC0;
            w_spec_flags = 5'b10000;
        end else if (w_a_inf) begin
            w_spec_res = {w_sign, 15'h7F80};
        end else if (w_b_inf) begin
            w_spec_res = {w_sign, 15'h0000};
        end else if (w_b_zero) begin
            w_spec_res   = {w_sign, 15'h7F80};
            w_spec_flags = 5'b01000;
        end else if (w_a_zero) begin
            w_spec_res = {w_sign, 15'h0000};
        end else begin
            w_special = 1'b0;
        end
    end

    // One restoring-division step
    logic       w_qbit;
    logic [8:0] w_rem_sub;

    assign w_qbit    = (r_rem >= {1'b0, r_mb});
    assign w_rem_sub = w_qbit ? (r_rem - {1'b0, r_mb}) : r_rem;

    // Normalise, round to nearest even, range check
    logic [7:0]        w_m, w_m_r;
    logic              w_g, w_st, w_inc;
    logic [8:0]        w_m_inc;
    logic signed [9:0] w_exp_n, w_exp_r;
    logic [15:0]       w_norm_res;
    logic [4:0]        w_norm_flags;

    always_comb begin
        if (r_q[10]) begin
            w_m     = r_q[10:3];
            w_g     = r_q[2];
            w_st    = (|r_q[1:0]) | (|r_rem);
            w_exp_n = r_exp + 10'sd1;
        end else begin
            w_m     = r_q[9:2];
            w_g     = r_q[1];
            w_st    = r_q[0] | (|r_rem);
            w_exp_n = r_exp;
        end
        w_inc   = w_g & (w_st | w_m[0]);
        w_m_inc = {1'b0, w_m} + {8'd0, w_inc};
        // Mantissa overflow from rounding renormalises to 1.0 and bumps exp
        if (w_m_inc[8]) begin
            w_m_r   = 8'h80;
            w_exp_r = w_exp_n + 10'sd1;
        end else begin
            w_m_r   = w_m_inc[7:0];
            w_exp_r = w_exp_n;
        end
        if (w_exp_r >= 10'sd255) begin
            w_norm_res   = {r_sign, 15'h7F80};
            w_norm_flags = 5'b00101;
        end else if (w_exp_r <= 10'sd0) begin
            w_norm_res   = {r_sign, 15'h0000};
            w_norm_flags = 5'b00011;
        end else begin
            w_norm_res   = {r_sign, w_exp_r[7:0], w_m_r[6:0]};
            w_norm_flags = {4'b0000, w_g | w_st};
        end
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (div_en_i) w_next = w_special ? S_DONE : S_DIV;
            S_DIV: begin
                if (!div_en_i)             w_next = S_IDLE;
                else if (r_cnt == LastCnt) w_next = S_NORM;
            end
            S_NORM: w_next = div_en_i ? S_DONE : S_IDLE;
            S_DONE: if (!div_en_i || ready_id_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Datapath and result registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= 4'd0;
            r_rem   <= 9'd0;
            r_mb    <= 8'd0;
            r_q     <= 11'd0;
            r_exp   <= 10'sd0;
            r_sign  <= 1'b0;
            r_res   <= 16'd0;
            r_flags <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (div_en_i && w_special) begin
                        r_res   <= w_spec_res;
                        r_flags <= w_spec_flags;
                    end else begin
                        r_res   <= 16'd0;
                        r_flags <= 5'd0;
                    end
                    if (div_en_i && !w_special) begin
                        r_rem  <= {2'b01, w_fa};
                        r_mb   <= {1'b1, w_fb};
                        r_q    <= 11'd0;
                        r_cnt  <= 4'd0;
                        r_sign <= w_sign;
                        r_exp  <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd126;
                    end
                end
                S_DIV: begin
                    r_rem <= {w_rem_sub[7:0], 1'b0};
                    r_q   <= {r_q[9:0], w_qbit};
                    r_cnt <= r_cnt + 4'd1;
                end
                S_NORM: begin
                    r_res   <= w_norm_res;
                    r_flags <= w_norm_flags;
                end
                default: ;
            endcase
            // Leaving an active state (handshake or abort) drops the result
            if ((r_state != S_IDLE) && (w_next == S_IDLE)) begin
                r_res   <= 16'd0;
                r_flags <= 5'd0;
                r_cnt   <= 4'd0;
            end
        end
    end

    assign valid_o     = (r_state == S_DONE);
    assign busy_o      = (r_state != S_IDLE);
    assign result_o    = {r_res, 16'h0000};
    assign flags_o     = r_flags;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_ibex_fp_div_bf16.sv
module tb_ibex_fp_div_bf16;

    logic        clk_i;
    logic        rst_ni;
    logic        div_en_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        ready_id_i;
    logic        valid_o;
    logic        busy_o;
    logic [31:0] result_o;
    logic [4:0]  flags_o;
    logic [1:0]  dbg_state_o;

    int checks   = 0;
    int failures = 0;

    ibex_fp_div_bf16 #(.NumIter(11)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .div_en_i    (div_en_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .ready_id_i  (ready_id_i),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .result_o    (result_o),
        .flags_o     (flags_o),
        .dbg_state_o (dbg_state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Starts an operation at cycle 0, measures latency to valid_o, checks
    // result/flags, holds ready low for 'hold' cycles, then handshakes.
    task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input int exp_lat, input logic [31:0] exp_res,
                           input logic [4:0] exp_flags, input int hold);
        int lat;
        @(posedge clk_i); #1;
        div_en_i    = 1'b1;
        ready_id_i  = 1'b0;
        operand_a_i = {a, 16'h1234};
        operand_b_i = {b, 16'hABCD};
        lat = 0;
        while (!valid_o && lat < 40) begin
            @(posedge clk_i); #1;
            lat++;
            // Later operand changes must not matter
            operand_a_i = $urandom();
            operand_b_i = $urandom();
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, result_o, exp_res);
        chk({tag, "_flags"}, {27'd0, flags_o}, {27'd0, exp_flags});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            chk({tag, "_hold_valid"}, {31'd0, valid_o}, 32'd1);
            chk({tag, "_hold_result"}, result_o, exp_res);
        end
        ready_id_i = 1'b1;
        @(posedge clk_i); #1;
        div_en_i   = 1'b0;
        ready_id_i = 1'b0;
        chk({tag, "_after_valid"}, {31'd0, valid_o}, 32'd0);
        chk({tag, "_after_result"}, result_o, 32'd0);
    endtask

    initial begin
        int vcount;
        rst_ni      = 1'b0;
        div_en_i    = 1'b0;
        ready_id_i  = 1'b0;
        operand_a_i = 32'd0;
        operand_b_i = 32'd0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_valid", {31'd0, valid_o}, 32'd0);
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        chk("reset_result", result_o, 32'd0);
        chk("reset_flags", {27'd0, flags_o}, 32'd0);
        chk("reset_state", {30'd0, dbg_state_o}, 32'd0);
        rst_ni = 1'b1;

        // Normal path
        run_div("one_by_one", 16'h3F80, 16'h3F80, 13, 32'h3F80_0000, 5'b00000, 4);
        run_div("one_third", 16'h3F80, 16'h4040, 13, 32'h3EAB_0000, 5'b00001, 0);
        run_div("two_by_one", 16'h4000, 16'h3F80, 13, 32'h4000_0000, 5'b00000, 0);
        run_div("neg_two", 16'hC000, 16'h3F80, 13, 32'hC000_0000, 5'b00000, 0);
        run_div("overflow", 16'h7F7F, 16'h0080, 13, 32'h7F80_0000, 5'b00101, 0);
        run_div("underflow", 16'h0080, 16'h7F7F, 13, 32'h0000_0000, 5'b00011, 0);

        // Special cases
        run_div("div_zero", 16'h3F80, 16'h0000, 1, 32'h7F80_0000, 5'b01000, 2);
        run_div("zero_zero", 16'h0000, 16'h0000, 1, 32'h7FC0_0000, 5'b10000, 0);
        run_div("nan_a", 16'h7FC1, 16'h3F80, 1, 32'h7FC0_0000, 5'b10000, 0);
        run_div("inf_inf", 16'h7F80, 16'hFF80, 1, 32'h7FC0_0000, 5'b10000, 0);
        run_div("inf_a", 16'h7F80, 16'h3F80, 1, 32'h7F80_0000, 5'b00000, 0);
        run_div("inf_b", 16'h3F80, 16'hFF80, 1, 32'h8000_0000, 5'b00000, 0);
        run_div("zero_a", 16'h8000, 16'h4000, 1, 32'h8000_0000, 5'b00000, 0);
        run_div("denorm_a", 16'h0001, 16'h3F80, 1, 32'h0000_0000, 5'b00000, 0);

        // Abort: drop enable in cycle 5
        @(posedge clk_i); #1;
        div_en_i    = 1'b1;
        operand_a_i = 32'h4000_0000;
        operand_b_i = 32'h3F80_0000;
        repeat (5) @(posedge clk_i);
        #1;
        chk("abort_busy_before", {31'd0, busy_o}, 32'd1);
        div_en_i = 1'b0;
        @(posedge clk_i); #1;
        chk("abort_state", {30'd0, dbg_state_o}, 32'd0);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i); #1;
            if (valid_o) vcount++;
        end
        chk("abort_no_valid", 32'(vcount), 32'd0);
        run_div("reenable", 16'h4000, 16'h3F80, 13, 32'h4000_0000, 5'b00000, 0);

        // Reset during DIV
        @(posedge clk_i); #1;
        div_en_i    = 1'b1;
        operand_a_i = 32'h3F80_0000;
        operand_b_i = 32'h4040_0000;
        repeat (4) @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_mid_result", result_o, 32'd0);
        chk("rst_mid_state", {30'd0, dbg_state_o}, 32'd0);
        div_en_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        run_div("after_reset", 16'h3F80, 16'h4040, 13, 32'h3EAB_0000, 5'b00001, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ibex_fp_div_bf16.md
# ibex_fp_div_bf16

Iterative bfloat16 divider that sits behind the execute block as a multi-cycle responder. It uses the same dynamic-enable / valid / ID-ready handshake the execute block already drives toward the multiplier/divider. The execute block raises the enable, and this block holds the result and exception flags until the ID stage accepts them. Operands and results are bfloat16 carried in bits [31:16] of 32-bit words.

## Interface
- `NumIter`, default 11: number of quotient bits produced, one per cycle. Fixed at 11; the rounding logic depends on it.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. One clock; reset is asynchronous and active-low.
- `div_en_i`  in  1  dynamic enable. High for the whole operation; low aborts.
- `operand_a_i`  in  32  dividend; bf16 in [31:16], [15:0] ignored.
- `operand_b_i`  in  32  divisor; bf16 in [31:16], [15:0] ignored.
- `ready_id_i`  in  1  ID stage accepts the result.
- `valid_o`  out  1  result and flags valid.
- `busy_o`  out  1  state is not IDLE.
- `result_o`  out  32  bf16 quotient in [31:16]; [15:0] always 0.
- `flags_o`  out  5  RISC-V fflags order: {NV, DZ, OF, UF, NX}.

## Operation
- Input decode:
  - s = bit 31, e = [30:23], f = [22:16].
  - Exponent 0 is treated as zero; denormals flush to zero with no flag.
  - Exponent 255 with f≠0 is NaN; exponent 255 with f=0 is infinity.
- Sign: s_q = s_a ^ s_b.
- Special cases, decided in IDLE and resolved without iterating:
  - NaN operand, 0/0 or inf/inf → 0x7FC0, NV.
  - a = inf → ±inf, no flag.
  - b = inf → ±0, no flag.
  - b = 0 with a finite and nonzero → ±inf, DZ.
  - a = 0 → ±0, no flag.
- Normal path, operands registered at start:
  - Mantissas ma = {1, f_a} and mb = {1, f_b}, 8 bits each.
  - Remainder r is 9 bits, initialised to ma.
  - Each DIV cycle: q_bit = (r ≥ mb); if set, r ← r − mb; then r ← r << 1; q ← {q[9:0], q_bit}.
- NORM, after 11 quotient bits q[10:0]:
  - If q[10]: m = q[10:3], g = q[2], st = |q[1:0] | (r≠0), exp = e_a − e_b + 127.
  - Else: m = q[9:2], g = q[1], st = q[0] | (r≠0), exp = e_a − e_b + 126.
  - exp is a 10-bit signed value.
- Rounding is round-to-nearest-even:
  - Increment m when g & (st | m[0]).
  - If m wraps to 0x100: m = 0x80 and exp + 1.
  - NX = g | st.
- Range check:
  - exp ≥ 255 → ±inf (0x7F80 | sign), OF | NX.
  - exp ≤ 0 → ±0, UF | NX.
  - Otherwise result = {s_q, exp[7:0], m[6:0]}.
- FSM states and transitions:
  - IDLE: if div_en_i, go to DONE when the operands are a special case, else DIV.
  - DIV: 11 cycles, tracked by a 4-bit counter 0..10; go to NORM after count 10.
  - NORM: one cycle; go to DONE.
  - DONE: go to IDLE on div_en_i & ready_id_i.
  - Abort: div_en_i low in any non-IDLE state → IDLE at the next edge. No result is produced and no flags are kept.

## Timing
- Reset: state IDLE, counter 0, valid_o = 0, busy_o = 0, result_o = 0, flags_o = 0. Reset mid-operation discards all state.
- Cycle 0 is the IDLE cycle in which div_en_i is sampled high; operands are captured at the end of cycle 0.
- Special-case path: valid_o high in cycle 1, a latency of 1.
- Normal path: DIV in cycles 1–11, NORM in cycle 12, valid_o high in cycle 13, a latency of 13.
- valid_o = (state == DONE), driven combinationally from the state register.
- result_o and flags_o:
  - Registered and stable for as long as DONE is held, including under any length of ready_id_i-low backpressure.
  - Cleared to 0 on the transition to IDLE.
- Operand changes after cycle 0 are ignored.
- After a handshake the block spends at least one IDLE cycle before the next operation. If div_en_i is still high in that IDLE cycle, a new operation starts with the operands present then.
- Simultaneous events:
  - ready_id_i high while not in DONE is ignored.
  - div_en_i low together with ready_id_i high in DONE counts as an abort, and the next state is IDLE either way.

## Test plan
- 0x3F80 / 0x3F80 (1.0/1.0) → valid_o in cycle 13, result 0x3F80_0000, flags 0; valid_o holds through 4 cycles of ready_id_i low with a stable result.
- 0x3F80 / 0x4040 (1/3) → result 0x3EAB_0000, flags 5'b00001 (NX) in cycle 13.
- 0x3F80 / 0x0000 → 0x7F80_0000, DZ (5'b01000) in cycle 1. 0x0000 / 0x0000 → 0x7FC0_0000, NV (5'b10000) in cycle 1.
- 0x7F7F / 0x0080 → 0x7F80_0000, OF|NX (5'b00101). 0x0080 / 0x7F7F → 0x0000_0000, UF|NX (5'b00011).
- Abort: start 0x4000/0x3F80, drop div_en_i in cycle 5 → IDLE in cycle 6 and valid_o never asserts. Re-enable with 0x4000/0x3F80 → 0x4000_0000 with valid_o 13 cycles later.
- Assert rst_ni low during DIV → all outputs 0 immediately, state IDLE.
